// File: rtl/rst_start_sequencer_pkg.sv
// Package: rst_seq_pkg
// Shared types and helpers for the reset/start sequencer.
// - seq_state_t : sequencer FSM states
// - cnt_width() : width of the shared holdoff/cycle counter
// - *_DEF       : default parameter values used by the top and its interface
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    IDLE       = 2'd1,
    BUSY       = 2'd2
  } seq_state_t;

  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned HOLDOFF_CLKS_DEF = 8;
  localparam int unsigned TIMEOUT_CLKS_DEF = 16;

  // The shared counter must hold the larger of the holdoff span and the
  // timeout value (BUSY counts up to TIMEOUT_CLKS inclusive).
  function automatic int unsigned cnt_width(input int unsigned holdoff,
                                            input int unsigned timeout);
    int unsigned m;
    m = (holdoff > timeout) ? holdoff : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_start_sequencer_if.sv
// Interface: rst_start_sequencer_if
// Bundles the start/done handshake and the sequencer status outputs.
// - start_i, done_i     : requests/strobes driven towards the sequencer
// - sync_reset_n_o      : synchronously released reset for the ALU core
// - ready_o, busy_o     : sequencer status
// - start_pulse_o       : one-cycle launch strobe
// - timeout_o           : one-cycle abort strobe
// - op_cycles_o         : BUSY cycle count of the last completed operation
// Modports: master = stimulus/ALU side, slave = sequencer side.
interface rst_start_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int unsigned CNT_W = cnt_width(HOLDOFF_CLKS_DEF, TIMEOUT_CLKS_DEF)
);

  logic             start_i;
  logic             done_i;
  logic             sync_reset_n_o;
  logic             ready_o;
  logic             busy_o;
  logic             start_pulse_o;
  logic             timeout_o;
  logic [CNT_W-1:0] op_cycles_o;

  modport master (
    output start_i,
    output done_i,
    input  sync_reset_n_o,
    input  ready_o,
    input  busy_o,
    input  start_pulse_o,
    input  timeout_o,
    input  op_cycles_o
  );

  modport slave (
    input  start_i,
    input  done_i,
    output sync_reset_n_o,
    output ready_o,
    output busy_o,
    output start_pulse_o,
    output timeout_o,
    output op_cycles_o
  );

endinterface

// File: rtl/rst_start_sequencer_reset_sync.sv
// Module: reset_sync
// Async-assert / sync-deassert reset synchroniser.
// - clk_i        : clock
// - rst_n_i      : asynchronous active-low reset
// - sync_rst_n_o : last synchroniser stage; rises STAGES posedges after release
module reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic sync_rst_n_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_start_sequencer.sv
// Module: rst_start_sequencer
// Turns raw clock/reset/start stimulus into a clean ALU reset, enforces a
// power-up holdoff, converts start rising edges into single-cycle launches
// and supervises completion with a timeout.
// Ports:
// - clk_i     : single clock, all flops on posedge
// - reset_n_i : asynchronous active-low reset
// - bus       : slave modport of rst_start_sequencer_if
//               (start_i/done_i in; sync_reset_n_o, ready_o, busy_o,
//                start_pulse_o, timeout_o, op_cycles_o out)
module rst_start_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int unsigned HOLDOFF_CLKS = HOLDOFF_CLKS_DEF,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
  parameter int unsigned CNT_W        = cnt_width(HOLDOFF_CLKS, TIMEOUT_CLKS)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  rst_start_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CLKS - 1);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] op_cycles_q, op_cycles_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             pulse_q, pulse_d;
  logic             timeout_q, timeout_d;
  logic             start_prev_q;
  logic             sync_rst_n;
  logic             start_edge;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk_i        (clk_i),
    .rst_n_i      (reset_n_i),
    .sync_rst_n_o (sync_rst_n)
  );

  // Edge detector resets to 1 so a start level held through reset is not
  // mistaken for a fresh request; it only tracks once reset is released.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      start_prev_q <= 1'b1;
    end else if (sync_rst_n) begin
      start_prev_q <= bus.start_i;
    end
  end

  assign start_edge = bus.start_i & ~start_prev_q;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RESET_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_HOLD: if (sync_rst_n && (cnt_q == HOLD_LAST)) state_d = IDLE;
      IDLE:       if (start_edge)                         state_d = BUSY;
      BUSY:       if (bus.done_i || (cnt_q == TMO_CNT))   state_d = IDLE;
      default:                                            state_d = RESET_HOLD;
    endcase
  end

  // Output / datapath next values. The counter is shared: it times the
  // holdoff in RESET_HOLD and counts BUSY cycles (starting at 1) per op.
  always_comb begin
    cnt_d       = cnt_q;
    op_cycles_d = op_cycles_q;
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    pulse_d     = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      RESET_HOLD: begin
        if (sync_rst_n) cnt_d = cnt_q + 1'b1;
        if (state_d == IDLE) begin
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (state_d == BUSY) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          pulse_d = 1'b1;
          cnt_d   = CNT_ONE;
        end
      end
      BUSY: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // done has priority over the timeout in the same cycle
        if (bus.done_i) begin
          op_cycles_d = cnt_q;
          busy_d      = 1'b0;
          ready_d     = 1'b1;
        end else if (cnt_q == TMO_CNT) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          ready_d   = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q       <= '0;
      op_cycles_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      pulse_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      op_cycles_q <= op_cycles_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      pulse_q     <= pulse_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.sync_reset_n_o = sync_rst_n;
  assign bus.ready_o        = ready_q;
  assign bus.busy_o         = busy_q;
  assign bus.start_pulse_o  = pulse_q;
  assign bus.timeout_o      = timeout_q;
  assign bus.op_cycles_o    = op_cycles_q;

endmodule

// File: tb/tb_rst_start_sequencer.sv
// Testbench: tb_rst_start_sequencer
// Directed stimulus with a scoreboard: expected events are queued as
// stimulus is issued, and a negedge monitor reconstructs events from the
// DUT outputs and compares them in order.
module tb_rst_start_sequencer;
  import rst_seq_pkg::*;

  localparam int unsigned CNT_W = cnt_width(8, 16);

  typedef enum int unsigned {EV_SYNC = 0, EV_READY = 1, EV_OP = 2} ev_kind_e;

  // SYNC/READY: a = posedge index after release
  // OP: a = busy length, b = op_cycles_o, c = timeout_o, d = ready_o, e = launch pulses
  typedef struct packed {
    ev_kind_e    kind;
    int unsigned a;
    int unsigned b;
    int unsigned c;
    int unsigned d;
    int unsigned e;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n_i;
  int   checks = 0;
  int   fails  = 0;
  ev_t  exp_q[$];
  int unsigned rel_cyc;
  int unsigned last_op;

  rst_start_sequencer_if #(.CNT_W(CNT_W)) bus ();

  rst_start_sequencer #(
    .SYNC_STAGES  (2),
    .HOLDOFF_CLKS (8),
    .TIMEOUT_CLKS (16)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) rel_cyc <= 0;
    else            rel_cyc <= rel_cyc + 1;
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic observe(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d c=%0d d=%0d e=%0d, required none",
               got.kind, got.a, got.b, got.c, got.d, got.e);
    end else begin
      e = exp_q.pop_front();
      if (got != e) begin
        fails++;
        $display("FAIL event_kind%0d: got a=%0d b=%0d c=%0d d=%0d e=%0d (kind %0d), required a=%0d b=%0d c=%0d d=%0d e=%0d (kind %0d)",
                 e.kind, got.a, got.b, got.c, got.d, got.e, got.kind,
                 e.a, e.b, e.c, e.d, e.e, e.kind);
      end
    end
  endtask

  logic        prev_sync, prev_ready, prev_busy;
  int unsigned busy_len, pulse_cnt;

  always @(negedge clk) begin
    if (!reset_n_i) begin
      checks++;
      if ({bus.sync_reset_n_o, bus.ready_o, bus.busy_o, bus.start_pulse_o, bus.timeout_o} !== 5'b0 ||
          bus.op_cycles_o !== '0) begin
        fails++;
        $display("FAIL rst_low_outputs: got sync/rdy/busy/pulse/tmo=%b%b%b%b%b op=%0d, required all 0",
                 bus.sync_reset_n_o, bus.ready_o, bus.busy_o, bus.start_pulse_o, bus.timeout_o,
                 bus.op_cycles_o);
      end
      prev_sync  = 1'b0;
      prev_ready = 1'b0;
      prev_busy  = 1'b0;
      busy_len   = 0;
      pulse_cnt  = 0;
    end else begin
      checks++;
      if ((bus.ready_o && bus.busy_o) || (bus.start_pulse_o && !bus.busy_o) ||
          (bus.timeout_o && !prev_busy)) begin
        fails++;
        $display("FAIL invariants: got rdy=%b busy=%b pulse=%b tmo=%b prev_busy=%b, required no overlap/stray strobe",
                 bus.ready_o, bus.busy_o, bus.start_pulse_o, bus.timeout_o, prev_busy);
      end
      if (bus.sync_reset_n_o && !prev_sync)
        observe('{kind: EV_SYNC, a: rel_cyc, b: 0, c: 0, d: 0, e: 0});
      if (bus.ready_o && !prev_ready && !prev_busy)
        observe('{kind: EV_READY, a: rel_cyc, b: 0, c: 0, d: 0, e: 0});
      if (bus.busy_o) begin
        busy_len++;
        if (bus.start_pulse_o) pulse_cnt++;
      end else if (prev_busy) begin
        observe('{kind: EV_OP, a: busy_len, b: int'(bus.op_cycles_o),
                  c: int'(bus.timeout_o), d: int'(bus.ready_o), e: pulse_cnt});
        busy_len  = 0;
        pulse_cnt = 0;
      end
      prev_sync  = bus.sync_reset_n_o;
      prev_ready = bus.ready_o;
      prev_busy  = bus.busy_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_op(input int unsigned len, input int unsigned op, input int unsigned tmo);
    exp_q.push_back('{kind: EV_OP, a: len, b: op, c: tmo, d: 1, e: 1});
  endtask

  task automatic wait_ready(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (bus.ready_o) break;
      @(posedge clk); #1;
    end
    checks++;
    if (!bus.ready_o) begin
      fails++;
      $display("FAIL ready_wait: got ready_o=0 after %0d cycles, required 1", budget);
    end
  endtask

  // Called a few ns after a posedge; asserts reset mid-cycle.
  task automatic reset_seq();
    #1 reset_n_i = 1'b0;
    #1;
    checks++;
    if ({bus.sync_reset_n_o, bus.ready_o, bus.busy_o, bus.start_pulse_o, bus.timeout_o} !== 5'b0 ||
        bus.op_cycles_o !== '0) begin
      fails++;
      $display("FAIL rst_immediate: got sync/rdy/busy/pulse/tmo=%b%b%b%b%b op=%0d, required all 0",
               bus.sync_reset_n_o, bus.ready_o, bus.busy_o, bus.start_pulse_o, bus.timeout_o,
               bus.op_cycles_o);
    end
    last_op = 0;
    exp_q.push_back('{kind: EV_SYNC,  a: 2,  b: 0, c: 0, d: 0, e: 0});
    exp_q.push_back('{kind: EV_READY, a: 10, b: 0, c: 0, d: 0, e: 0});
    repeat (5) @(posedge clk);
    #1 reset_n_i = 1'b1;
    wait_ready(30);
  endtask

  // Launch with a clean rising edge; done_cyc = 0 means no done (timeout).
  // noisy toggles start_i every BUSY cycle to create ignored edges.
  task automatic do_op(input int unsigned done_cyc, input bit noisy);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    for (int unsigned c = 1; c <= 20; c++) begin
      bus.start_i = noisy ? c[0] : 1'b0;
      if (c == done_cyc) bus.done_i = 1'b1;
      @(posedge clk); #1;
      bus.done_i = 1'b0;
      if (c == done_cyc) break;
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n_i   = 1'b1;
    bus.start_i = 1'b0;
    bus.done_i  = 1'b0;
    last_op     = 0;
    #1;
    reset_seq();

    // done on 3rd BUSY cycle
    push_op(3, 3, 0); last_op = 3;
    do_op(3, 1'b0);

    // no done: timeout after 16 cycles, op_cycles held
    push_op(16, last_op, 1);
    do_op(0, 1'b0);

    // done coincides with timeout count: done wins
    push_op(16, 16, 0); last_op = 16;
    do_op(16, 1'b0);

    // done while IDLE is ignored (no event expected)
    bus.done_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.done_i = 1'b0;
    @(posedge clk); #1;

    // extra start edges during BUSY: single launch only
    push_op(5, 5, 0); last_op = 5;
    do_op(5, 1'b1);

    // back-to-back: second edge sampled in first IDLE cycle
    push_op(2, 2, 0);
    push_op(1, 1, 0); last_op = 1;
    bus.start_i = 1'b1; @(posedge clk); #1;
    bus.start_i = 1'b0; @(posedge clk); #1;
    bus.done_i  = 1'b1; @(posedge clk); #1;
    bus.done_i  = 1'b0; bus.start_i = 1'b1; @(posedge clk); #1;
    bus.done_i  = 1'b1; bus.start_i = 1'b0; @(posedge clk); #1;
    bus.done_i  = 1'b0; @(posedge clk); #1;

    // start held high through reset: no launch until it drops and rises
    bus.start_i = 1'b1;
    reset_seq();
    repeat (5) @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(posedge clk); #1;
    push_op(2, 2, 0); last_op = 2;
    do_op(2, 1'b0);

    // reset at BUSY cycle 4: abort, no timeout, release sequence repeats
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1 bus.start_i = 1'b0;
    reset_seq();

    // op_cycles cleared by reset, held across a timeout
    push_op(16, last_op, 1);
    do_op(0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d unobserved, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
